// File: rtl/handshake_feeder_pkg.sv
// Shared definitions for handshake_feeder: state encoding, widths and sample table.
// Optional feature macro used by this slice: HSF_TIMEOUT_EN.
package handshake_feeder_pkg;

    // Global data size; default width of the samples fed to the processor.
    localparam int HSF_DATA_W  = 8;
    localparam int HSF_TO_W    = 16;
    localparam int HSF_SETUP_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PRESENT,
        WAIT_ACK,
        FINISH,
        ERROR
    } hsf_state_t;

    // Sample table; mirrors the contents of feeder_samples.hex.
    localparam logic [7:0] HSF_SAMPLES [16] = '{
        8'h05, 8'h03, 8'h7F, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44,
        8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC
    };

endpackage

// File: rtl/handshake_feeder_rom.sv
// feeder_rom: combinational sample lookup, index k -> DATA_W sample value.
// Contents follow feeder_samples.hex (held in the shared package table).
module feeder_rom
    import handshake_feeder_pkg::*;
#(
    parameter int DATA_W    = HSF_DATA_W,
    parameter int N_SAMPLES = 4,
    parameter int K_W       = $clog2(N_SAMPLES)
) (
    input  logic [K_W-1:0]    k,
    output logic [DATA_W-1:0] sample
);

    logic [DATA_W-1:0] rom [N_SAMPLES];

    genvar gi;
    generate
        for (gi = 0; gi < N_SAMPLES; gi++) begin : g_rom
            assign rom[gi] = DATA_W'(HSF_SAMPLES[gi]);
        end
    endgenerate

    assign sample = rom[k];

endmodule

// File: rtl/handshake_feeder.sv
// handshake_feeder: presents N_SAMPLES values to a processor load, toggling the
// handshake level per sample and waiting for ld_ack. Optional timeout: HSF_TIMEOUT_EN.
module handshake_feeder
    import handshake_feeder_pkg::*;
#(
    parameter int DATA_W      = HSF_DATA_W,
    parameter int N_SAMPLES   = 4,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_ack,
    output logic              handshake_switch,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                     K_W        = $clog2(N_SAMPLES);
    localparam logic [K_W-1:0]         K_LAST     = K_W'(N_SAMPLES - 1);
    localparam logic [HSF_SETUP_W-1:0] SETUP_LAST = HSF_SETUP_W'(SETUP_CYC - 1);

    hsf_state_t             state_reg, state_next;
    logic [K_W-1:0]         k_reg, k_next;
    logic [HSF_SETUP_W-1:0] setup_cnt_reg, setup_cnt_next;
    logic                   switch_reg, switch_next;
    logic [DATA_W-1:0]      sample;

`ifdef HSF_TIMEOUT_EN
    localparam logic [HSF_TO_W-1:0] TO_LAST = HSF_TO_W'(TIMEOUT_CYC - 1);

    logic [HSF_TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic                err_reg, err_next;
`endif

    feeder_rom #(
        .DATA_W    (DATA_W),
        .N_SAMPLES (N_SAMPLES),
        .K_W       (K_W)
    ) u_rom (
        .k      (k_reg),
        .sample (sample)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            setup_cnt_reg <= '0;
            switch_reg    <= 1'b1;
`ifdef HSF_TIMEOUT_EN
            to_cnt_reg    <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            setup_cnt_reg <= setup_cnt_next;
            switch_reg    <= switch_next;
`ifdef HSF_TIMEOUT_EN
            to_cnt_reg    <= to_cnt_next;
            err_reg       <= err_next;
`endif
        end
    end

    // The switch level is registered, so the toggle decided in PRESENT is seen
    // from the first WAIT_ACK cycle and held until the next PRESENT or FINISH.
    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        setup_cnt_next = setup_cnt_reg;
        switch_next    = switch_reg;
`ifdef HSF_TIMEOUT_EN
        to_cnt_next    = to_cnt_reg;
        err_next       = err_reg;
`endif
        case (state_reg)
            IDLE, ERROR: begin
                if (start) begin
                    state_next     = SETUP;
                    k_next         = '0;
                    setup_cnt_next = '0;
`ifdef HSF_TIMEOUT_EN
                    err_next       = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (setup_cnt_reg == SETUP_LAST) begin
                    state_next     = PRESENT;
                    setup_cnt_next = '0;
                end else begin
                    setup_cnt_next = setup_cnt_reg + 1'b1;
                end
            end
            PRESENT: begin
                switch_next = k_reg[0];
                state_next  = WAIT_ACK;
`ifdef HSF_TIMEOUT_EN
                to_cnt_next = '0;
`endif
            end
            WAIT_ACK: begin
                // Acknowledge wins over an expiring timer in the same cycle.
                if (ld_ack) begin
                    if (k_reg == K_LAST) begin
                        state_next = FINISH;
                    end else begin
                        k_next     = k_reg + 1'b1;
                        state_next = SETUP;
                    end
                end
`ifdef HSF_TIMEOUT_EN
                else if (to_cnt_reg == TO_LAST) begin
                    state_next = ERROR;
                    err_next   = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
`endif
            end
            FINISH: begin
                switch_next = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign handshake_switch = switch_reg;
    assign busy             = state_reg inside {SETUP, PRESENT, WAIT_ACK, FINISH};
    assign done             = (state_reg == FINISH);
    assign data_out         = (state_reg inside {SETUP, PRESENT, WAIT_ACK}) ? sample : '0;

`ifdef HSF_TIMEOUT_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/handshake_feeder.md
HANDSHAKE_FEEDER -- requirements
Module: handshake_feeder

Interface
REQ-001 Parameter DATA_W, default 8: width of the sample presented to the processor data input.
REQ-002 Parameter N_SAMPLES, default 4: samples per run, range 2..16.
REQ-003 Parameter SETUP_CYC, default 2: cycles data_out is stable before handshake_switch toggles, range 1..15.
REQ-004 Parameter TIMEOUT_CYC, default 1023: maximum wait for ld_ack, range 1..65535.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a run when idle.
REQ-008 ld_ack  input  1  processor pulse: WLD0/WLD1 completed and register written.
REQ-009 handshake_switch  output  1  handshake level driven to the processor decoder.
REQ-010 data_out  output  DATA_W  sample value seen by the processor load.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse after the final sample is acknowledged.
REQ-013 err  output  1  sticky timeout flag, cleared by start or reset (only with HSF_TIMEOUT_EN).

Function
REQ-014 FSM states SHALL be IDLE, SETUP, PRESENT, WAIT_ACK, FINISH, ERROR.
REQ-015 IDLE: start=1 -> SETUP, with sample index k=0 and busy=1 from the next cycle.
REQ-016 SETUP: data_out = sample[k], switch holds its previous level for exactly SETUP_CYC cycles, then -> PRESENT.
REQ-017 PRESENT: switch = k[0] (even k drives 0 for WLD0, odd k drives 1 for WLD1), lasting one cycle, then -> WAIT_ACK.
REQ-018 WAIT_ACK: data_out and switch held; ld_ack=1 -> k+1; if k was N_SAMPLES-1 -> FINISH, else -> SETUP.
REQ-019 FINISH: done=1 for one cycle, switch restored to 1, -> IDLE.
REQ-020 ld_ack outside WAIT_ACK SHALL be ignored; start outside IDLE/ERROR SHALL be ignored.
REQ-021 ld_ack in the same cycle the wait counter expires SHALL count as acknowledge, with no error.
REQ-022 Index k SHALL be $clog2(N_SAMPLES) bits wide and SHALL never wrap within a run.
REQ-023 Latency start -> first switch toggle = SETUP_CYC+2 cycles; ld_ack -> next toggle = SETUP_CYC+2 cycles.

Reset
REQ-024 Reset, including mid-run, SHALL force IDLE, k=0, handshake_switch=1, data_out=0, busy=0, done=0, err=0.
REQ-025 The idle switch level of 1 SHALL stall a processor sitting on WLD0 until a run starts.

Configuration
REQ-026 Macro HSF_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_ACK; reaching TIMEOUT_CYC -> ERROR with err=1 and busy=0; start in ERROR -> SETUP with k=0 and err cleared.
REQ-027 Macro HSF_TIMEOUT_EN undefined: no counter, ERROR unreachable, err tied to 0, WAIT_ACK waits indefinitely.

Structure
REQ-028 The shared package SHALL hold the state enum hsf_state_t, the DATA_W default taken from the global parameter data size, and the timeout counter width.
REQ-029 Sample values SHALL come from sub-module feeder_rom (combinational, index k -> DATA_W value, contents initialised from file feeder_samples.hex).

Verification
REQ-030 ROM {0x05,0x03,0x7F,0x80}, SETUP_CYC=2, start, ld_ack 3 cycles after each toggle -> switch sequence 1->0->1->0->1, data_out 0x05,0x03,0x7F,0x80, done pulse once, busy low afterwards.
REQ-031 ld_ack pulsed during SETUP and during IDLE -> no change to k or switch.
REQ-032 Reset asserted in WAIT_ACK for sample 2 -> switch=1, data_out=0, busy=0 immediately (asynchronous), then a clean rerun from sample 0.
REQ-033 With HSF_TIMEOUT_EN and TIMEOUT_CYC=10, no ld_ack -> err=1 exactly 10 cycles into WAIT_ACK; start -> err=0 and switch 0 after SETUP_CYC+2 cycles.
REQ-034 With HSF_TIMEOUT_EN, ld_ack on the expiry cycle -> err stays 0 and the run continues.
REQ-035 Without HSF_TIMEOUT_EN, 70000 cycles with no ld_ack -> busy stays 1, err=0, then ld_ack resumes the run.
